seg_display_arbiter: RTL and testbench

Shares the 4-digit hex seven-segment display between up to four 16-bit status sources (e.g. PC, IR, MDR, a debug register) plus one high-priority override requester. Rotates through valid sources on a dwell timer or a manual button pulse and marks the shown source by lighting its digit's decimal point. Sits between the core/debug logic and the existing hex display driver, feeding that driver's `digits`, `ones_place` and `dp_en` inputs directly.

---
 rtl/seg_display_pkg.sv | 13 +
 rtl/rr_next_sel.sv | 33 +++
 rtl/seg_display_arbiter.sv | 164 ++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ROTATE   = 2'd1,
    ST_OVERRIDE = 2'd2
  } arb_state_e;

  localparam int SEG_DIGITS = 4;
  localparam int SEL_W      = 2;

endpackage

// File: rtl/rr_next_sel.sv
// Combinational round-robin finder: first set valid bit starting at start
// (inclusive) or start+1 (exclusive, wrapping back to start as last resort).
module rr_next_sel
  import seg_display_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [SEL_W-1:0]   start,
  input  logic               inclusive,
  output logic [SEL_W-1:0]   next,
  output logic               found
);

  int cand;

  always_comb begin
    next  = start;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = int'(start) + k + (inclusive ? 0 : 1);
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!found && cand == j && valid[j]) begin
          found = 1'b1;
          next  = SEL_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares the 4-digit hex display between NUM_SRC status sources and one
// priority override; every output is registered from the next-state values.
module seg_display_arbiter
  import seg_display_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int HOLD_CYCLES  = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [16*NUM_SRC-1:0]   src_value,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic                    auto_en,
  input  logic                    btn_next,
  input  logic                    ovr_req,
  input  logic [15:0]             ovr_value,
  output logic                    ovr_gnt,
  output logic [SEL_W-1:0]        sel,
  output logic [4*SEG_DIGITS-1:0] digits,
  output logic [SEL_W-1:0]        ones_place,
  output logic                    dp_en
);

  localparam int DIGITS_W = 4 * SEG_DIGITS;
  localparam int DWELL_W  = $clog2(DWELL_CYCLES);
  localparam int HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

  arb_state_e          state, state_d;
  logic [SEL_W-1:0]    sel_d;
  logic [DWELL_W-1:0]  dwell, dwell_d;
  logic [HOLD_W-1:0]   hold, hold_d;
  logic [DIGITS_W-1:0] digits_d;
  logic                dp_en_d, ovr_gnt_d;

  logic [SEL_W-1:0]    rr_next;
  logic                rr_found;
  logic                any_valid, cur_valid;
  logic [15:0]         next_value;

  assign any_valid  = |src_valid;
  assign ones_place = sel;

  // Leaving IDLE or OVERRIDE keeps the current source if it is still valid;
  // an advance from ROTATE looks past it first.
  rr_next_sel #(.NUM_SRC(NUM_SRC)) u_rr (
    .valid     (src_valid),
    .start     (sel),
    .inclusive (state != ST_ROTATE),
    .next      (rr_next),
    .found     (rr_found)
  );

  always_comb begin
    cur_valid = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (sel == SEL_W'(j)) cur_valid = src_valid[j];
    end
  end

  always_comb begin
    next_value = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (sel_d == SEL_W'(j)) next_value = src_value[16*j +: 16];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= '0;
      dwell <= '0;
      hold  <= '0;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      dwell <= dwell_d;
      hold  <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    sel_d   = sel;
    dwell_d = dwell;
    hold_d  = hold;
    unique case (state)
      ST_IDLE: begin
        if (ovr_req) begin
          state_d = ST_OVERRIDE;
          hold_d  = '0;
        end else if (any_valid && rr_found) begin
          state_d = ST_ROTATE;
          sel_d   = rr_next;
          dwell_d = '0;
        end
      end
      ST_ROTATE: begin
        if (ovr_req) begin
          state_d = ST_OVERRIDE;
          hold_d  = '0;
        end else if (!any_valid) begin
          state_d = ST_IDLE;
        end else if (!cur_valid || btn_next || (auto_en && dwell == DWELL_LAST)) begin
          sel_d   = rr_next;
          dwell_d = '0;
        end else if (auto_en) begin
          dwell_d = dwell + 1'b1;
        end else begin
          dwell_d = '0;
        end
      end
      ST_OVERRIDE: begin
        if (hold != HOLD_LAST) hold_d = hold + 1'b1;
        if (!ovr_req && hold == HOLD_LAST) begin
          hold_d  = '0;
          dwell_d = '0;
          if (any_valid && rr_found) begin
            state_d = ST_ROTATE;
            sel_d   = rr_next;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic, evaluated on next state so outputs land one cycle after cause
  always_comb begin
    digits_d  = '0;
    dp_en_d   = 1'b0;
    ovr_gnt_d = 1'b0;
    unique case (state_d)
      ST_OVERRIDE: begin
        ovr_gnt_d = 1'b1;
        digits_d  = ovr_value;
      end
      ST_ROTATE: begin
        dp_en_d  = 1'b1;
        digits_d = next_value;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits  <= '0;
      dp_en   <= 1'b0;
      ovr_gnt <= 1'b0;
    end else begin
      digits  <= digits_d;
      dp_en   <= dp_en_d;
      ovr_gnt <= ovr_gnt_d;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with NUM_SRC=4, DWELL=8, HOLD=4.
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] src_value;
  logic [3:0]  src_valid;
  logic        auto_en, btn_next, ovr_req;
  logic [15:0] ovr_value;
  logic        ovr_gnt, dp_en;
  logic [1:0]  sel, ones_place;
  logic [15:0] digits;

  int checks = 0;
  int errors = 0;

  seg_display_arbiter #(
    .NUM_SRC(4), .DWELL_CYCLES(8), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_value(src_value), .src_valid(src_valid),
    .auto_en(auto_en), .btn_next(btn_next), .ovr_req(ovr_req),
    .ovr_value(ovr_value), .ovr_gnt(ovr_gnt), .sel(sel), .digits(digits),
    .ones_place(ones_place), .dp_en(dp_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        btn;
    logic        gnt;
    logic [1:0]  sel;
    logic [15:0] dig;
    logic        dp;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic gnt, input logic [1:0] s,
                           input logic [15:0] dig, input logic dp);
    check({tag, " ovr_gnt"}, 32'(ovr_gnt), 32'(gnt));
    check({tag, " sel"}, 32'(sel), 32'(s));
    check({tag, " ones_place"}, 32'(ones_place), 32'(s));
    check({tag, " digits"}, 32'(digits), 32'(dig));
    check({tag, " dp_en"}, 32'(dp_en), 32'(dp));
  endtask

  initial begin
    logic [1:0]  seq [4];
    logic [15:0] vals [4];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd3; seq[3] = 2'd0;

    // Override sequence at sel=1: req for 2 cycles, a stray btn during override.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 2'd1, 16'hDEAD, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 2'd1, 16'hDEAD, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 2'd1, 16'hDEAD, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 2'd1, 16'hDEAD, 1'b0};
    for (int i = 4; i < 12; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 2'd1, 16'h2222, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd3, 16'h4444, 1'b1};

    src_value = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    src_valid = 4'b0000;
    auto_en = 1'b0; btn_next = 1'b0; ovr_req = 1'b0; ovr_value = 16'h0000;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all("reset", 1'b0, 2'd0, 16'h0000, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // No valid sources: display stays blank.
    for (int i = 0; i < 20; i++) begin
      tick();
      check_all("idle", 1'b0, 2'd0, 16'h0000, 1'b0);
    end

    // Auto rotation over valid 1011: 0,1,3,0 with 8 cycles each.
    src_valid = 4'b1011;
    auto_en = 1'b1;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        check_all("auto", 1'b0, seq[g], vals[seq[g]], 1'b1);
      end
    end

    // Manual mode: dwell expiry ignored, button advances.
    auto_en = 1'b0;
    tick();
    check_all("manual hold", 1'b0, 2'd0, 16'h1111, 1'b1);
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    check_all("btn 0->1", 1'b0, 2'd1, 16'h2222, 1'b1);
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    check_all("btn 1->3", 1'b0, 2'd3, 16'h4444, 1'b1);
    for (int i = 0; i < 50; i++) begin
      tick();
      check_all("manual steady", 1'b0, 2'd3, 16'h4444, 1'b1);
    end
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    check_all("btn 3->0", 1'b0, 2'd0, 16'h1111, 1'b1);
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    check_all("btn 0->1 again", 1'b0, 2'd1, 16'h2222, 1'b1);

    // Override then full dwell back on sel=1.
    ovr_value = 16'hDEAD;
    auto_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      ovr_req  = tbl[i].req;
      btn_next = tbl[i].btn;
      tick();
      check_all($sformatf("ovr row %0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].dig, tbl[i].dp);
    end
    btn_next = 1'b0;

    // Current source dropping out forces an advance; all dropping goes idle.
    auto_en = 1'b0;
    src_valid = 4'b1001;
    tick();
    check_all("valid 1001", 1'b0, 2'd3, 16'h4444, 1'b1);
    src_valid = 4'b0001;
    tick();
    check_all("drop sel3", 1'b0, 2'd0, 16'h1111, 1'b1);
    src_value[15:0] = 16'hBEEF;
    tick();
    check_all("value follow", 1'b0, 2'd0, 16'hBEEF, 1'b1);
    src_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("drop all", 1'b0, 2'd0, 16'h0000, 1'b0);
    end

    // Async reset in the middle of an override.
    src_valid = 4'b0100;
    tick();
    check_all("rotate to 2", 1'b0, 2'd2, 16'h3333, 1'b1);
    ovr_req = 1'b1;
    tick();
    check_all("ovr before reset", 1'b1, 2'd2, 16'hDEAD, 1'b0);
    rst_n = 1'b0;
    #1 check_all("async reset", 1'b0, 2'd0, 16'h0000, 1'b0);
    tick();
    check_all("in reset", 1'b0, 2'd0, 16'h0000, 1'b0);
    ovr_req = 1'b0;
    src_valid = 4'b0000;
    rst_n = 1'b1;
    tick();
    check_all("after reset", 1'b0, 2'd0, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
